// File: rtl/bus_xfer_ctrl_if.sv
// Command and register-strobe bundle between a command source and bus_xfer_ctrl.
interface bus_xfer_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;
  logic [3:0] cmd_imm;
  logic [3:0] im;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic [3:0] ws1;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] xfer_cnt;

  // Command source side
  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
    input  cmd_ready, im, rs1, rs2, ws1, busy, done, err, xfer_cnt
  );

  // Controller side
  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
    output cmd_ready, im, rs1, rs2, ws1, busy, done, err, xfer_cnt
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer controller: sequences LDI (immediate load) and MOV (register to
// register over a shared bus) commands into one-hot register strobes.
module bus_xfer_ctrl #(
  parameter int NREG = 4,
  parameter int TURN = 1
) (
  input logic          clk,
  input logic          rst,
  bus_xfer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IMM,
    ST_DRIVE,
    ST_LATCH,
    ST_TURN,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_LDI = 2'b01,
    OP_MOV = 2'b10,
    OP_ILL = 2'b11
  } op_t;

  state_t           state;
  logic [NREG-1:0]  rs1_q;
  logic [NREG-1:0]  rs2_q;
  logic [NREG-1:0]  ws1_q;
  logic [3:0]       im_q;
  logic [1:0]       dst_q;
  logic             ill_q;
  logic             count_q;
  logic [1:0]       turn_left;
  logic [7:0]       cnt_q;

  function automatic logic [NREG-1:0] sel(input logic [1:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Command sequencing; strobes are registered alongside the state so they
  // change on the same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      ws1_q     <= '0;
      im_q      <= '0;
      dst_q     <= '0;
      ill_q     <= 1'b0;
      count_q   <= 1'b0;
      turn_left <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            dst_q <= bus.cmd_dst;
            ill_q <= (op_t'(bus.cmd_op) == OP_ILL);
            if (op_t'(bus.cmd_op) == OP_LDI) begin
              rs1_q   <= sel(bus.cmd_dst);
              im_q    <= bus.cmd_imm;
              count_q <= 1'b1;
              state   <= ST_IMM;
            end else if (op_t'(bus.cmd_op) == OP_MOV && bus.cmd_src != bus.cmd_dst) begin
              ws1_q   <= sel(bus.cmd_src);
              count_q <= 1'b1;
              state   <= ST_DRIVE;
            end else begin
              count_q <= 1'b0;
              state   <= ST_FIN;
            end
          end
        end
        ST_IMM: begin
          rs1_q <= '0;
          state <= ST_FIN;
        end
        ST_DRIVE: begin
          // Source keeps driving; destination latches after a full settle cycle.
          rs2_q <= sel(dst_q);
          state <= ST_LATCH;
        end
        ST_LATCH: begin
          ws1_q     <= '0;
          rs2_q     <= '0;
          turn_left <= 2'(TURN - 1);
          state     <= ST_TURN;
        end
        ST_TURN: begin
          if (turn_left == '0) begin
            state <= ST_FIN;
          end else begin
            turn_left <= turn_left - 2'd1;
          end
        end
        ST_FIN: begin
          if (count_q) begin
            cnt_q <= cnt_q + 8'd1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status decoded from registered state; ready is additionally masked by reset.
  always_comb begin
    bus.cmd_ready = (state == ST_IDLE) && !rst;
    bus.busy      = (state != ST_IDLE);
    bus.done      = (state == ST_FIN);
    bus.err       = (state == ST_FIN) && ill_q;
    bus.im        = im_q;
    bus.rs1       = rs1_q;
    bus.rs2       = rs2_q;
    bus.ws1       = ws1_q;
    bus.xfer_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed scenarios plus random command
// streams compared cycle-by-cycle against an expected-output queue.
module tb_bus_xfer_ctrl;
  localparam int TB_TURN = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_xfer_ctrl_if bif();

  bus_xfer_ctrl #(.NREG(4), .TURN(TB_TURN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] ws1;
    logic [3:0] im;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cnt;
    logic       idle;
  } rec_t;

  rec_t       exp_q[$];
  logic [3:0] im_m     = '0;
  logic [7:0] cnt_m    = '0;
  logic [3:0] prev_ws1 = '0;
  logic       cur_idle = 1'b0;
  logic       hold_valid = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Expected cycles for one accepted command, built from the op's rules.
  function automatic void push_trace(input logic [1:0] op, input logic [1:0] src,
                                     input logic [1:0] dst, input logic [3:0] imm);
    rec_t r;
    r = '0;
    r.busy = 1'b1;
    r.cnt  = cnt_m;
    if (op == 2'b01) begin
      im_m  = imm;
      r.im  = im_m;
      r.rs1 = oh(dst);
      exp_q.push_back(r);
      r.rs1  = '0;
      r.done = 1'b1;
      exp_q.push_back(r);
      cnt_m = cnt_m + 8'd1;
    end else if (op == 2'b10 && src != dst) begin
      r.im  = im_m;
      r.ws1 = oh(src);
      exp_q.push_back(r);
      r.rs2 = oh(dst);
      exp_q.push_back(r);
      r.ws1 = '0;
      r.rs2 = '0;
      for (int t = 0; t < TB_TURN; t++) exp_q.push_back(r);
      r.done = 1'b1;
      exp_q.push_back(r);
      cnt_m = cnt_m + 8'd1;
    end else begin
      r.im   = im_m;
      r.done = 1'b1;
      r.err  = (op == 2'b11);
      exp_q.push_back(r);
    end
  endfunction

  // One cycle: sample at negedge and compare against the next expected record.
  task automatic tick();
    rec_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e      = '0;
      e.im   = im_m;
      e.cnt  = cnt_m;
      e.idle = 1'b1;
    end
    cur_idle = e.idle;
    chk("cmd_ready", 32'(bif.cmd_ready), 32'(e.idle && !rst));
    chk("rs1",       32'(bif.rs1),       32'(e.rs1));
    chk("rs2",       32'(bif.rs2),       32'(e.rs2));
    chk("ws1",       32'(bif.ws1),       32'(e.ws1));
    chk("im",        32'(bif.im),        32'(e.im));
    chk("busy",      32'(bif.busy),      32'(e.busy));
    chk("done",      32'(bif.done),      32'(e.done));
    chk("err",       32'(bif.err),       32'(e.err));
    chk("xfer_cnt",  32'(bif.xfer_cnt),  32'(e.cnt));
    chk("ws1_onehot0",   32'($onehot0(bif.ws1)), 32'd1);
    chk("rs1_rs2_excl",  32'((bif.rs1 != 4'd0) && (bif.rs2 != 4'd0)), 32'd0);
    chk("rs2_after_ws1", 32'((bif.rs2 == 4'd0) || ((prev_ws1 & bif.ws1) != 4'd0)), 32'd1);
    prev_ws1 = bif.ws1;
  endtask

  // Garbage on the command inputs while the controller is busy.
  task automatic drive_busy();
    bif.cmd_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
    bif.cmd_op    = 2'($urandom_range(0, 3));
    bif.cmd_src   = 2'($urandom_range(0, 3));
    bif.cmd_dst   = 2'($urandom_range(0, 3));
    bif.cmd_imm   = 4'($urandom_range(0, 15));
  endtask

  task automatic present(input logic [1:0] op, input logic [1:0] src,
                         input logic [1:0] dst, input logic [3:0] imm);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_src   = src;
    bif.cmd_dst   = dst;
    bif.cmd_imm   = imm;
    if (cur_idle && !rst) push_trace(op, src, dst, imm);
  endtask

  // Present a command in the current idle cycle and run until idle again.
  task automatic issue(input logic [1:0] op, input logic [1:0] src,
                       input logic [1:0] dst, input logic [3:0] imm);
    int unsigned n;
    present(op, src, dst, imm);
    n = 0;
    do begin
      tick();
      if (!cur_idle) drive_busy();
      n++;
    end while (!cur_idle && n < 20);
    chk("op_completes", 32'(cur_idle), 32'd1);
    bif.cmd_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = 2'b01;
    bif.cmd_src   = 2'd0;
    bif.cmd_dst   = 2'd3;
    bif.cmd_imm   = 4'hF;

    // Reset with a command presented: it must be dropped.
    @(posedge clk);
    tick();
    tick();
    rst = 1'b0;
    bif.cmd_valid = 1'b0;
    tick();

    // LDI dst=0 imm=1001, then MOV 0->1
    issue(2'b01, 2'd0, 2'd0, 4'b1001);
    chk("cnt_after_ldi", 32'(bif.xfer_cnt), 32'd1);
    issue(2'b10, 2'd0, 2'd1, 4'h0);
    // Illegal op, self-MOV, NOP: no strobes, immediate done
    issue(2'b11, 2'd1, 2'd2, 4'h5);
    issue(2'b10, 2'd2, 2'd2, 4'h6);
    issue(2'b00, 2'd3, 2'd1, 4'h7);
    chk("im_hold", 32'(bif.im), 32'b1001);

    // Back-to-back with cmd_valid held high through busy
    hold_valid = 1'b1;
    issue(2'b01, 2'd2, 2'd3, 4'h3);
    issue(2'b10, 2'd3, 2'd0, 4'hC);
    issue(2'b01, 2'd0, 2'd1, 4'hA);
    hold_valid = 1'b0;

    // Random command stream with random idle gaps
    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        bif.cmd_valid = 1'b0;
        bif.cmd_op    = 2'($urandom_range(0, 3));
        tick();
      end
    end

    // Reset during LATCH of a MOV
    present(2'b10, 2'd1, 2'd3, 4'h0);
    tick();
    drive_busy();
    tick();
    rst = 1'b1;
    bif.cmd_valid = 1'b0;
    exp_q.delete();
    cnt_m = '0;
    im_m  = '0;
    tick();
    rst = 1'b0;
    tick();

    // 256 LDIs: counter wraps back to zero
    hold_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      issue(2'b01, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
    end
    hold_valid = 1'b0;
    chk("cnt_wrap", 32'(bif.xfer_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
